branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- ID-stage control-flow resolver plus program-counter register for the 5-stage MIPS pipeline.
- Consumes the jump/branch forwarding selects and jump stall from the jump forwarding unit.
- Muxes forwarded operands, evaluates beq/bne, and computes j/jal/jr/jalr targets.
- Owns the PC register, IF/ID write enable and IF/ID flush, and holds a pending redirect across ICache stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath and PC width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ICache_stall  in  1  global freeze from instruction/data cache.
- stallJ  in  1  jump/branch operand hazard from the forwarding unit.
- stall_load  in  1  load-use hazard from the main hazard unit.
- ForwardJA  in  2  operand A select: 00 RF, 01 EXMEM, 10 MEMWB.
- ForwardJB  in  2  operand B select, same encoding.
- RF_ReadData1  in  32  register-file rs value.
- RF_ReadData2  in  32  register-file rt value.
- EXMEM_ALUResult  in  32  EX/MEM forwarded value.
- MEMWB_WriteData  in  32  MEM/WB forwarded value.
- IFID_PC4  in  32  PC+4 of the instruction currently in ID.
- Branch  in  1  ID instruction is beq/bne.
- BranchNe  in  1  1 = bne, 0 = beq.
- Jump  in  1  j/jal.
- JumpR  in  1  jr/jalr.
- Imm16  in  16  branch offset.
- JIdx26  in  26  jump index.
- PC  out  32  fetch address to ICache.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  zero the IF/ID register this edge.
- redirect_pending  out  1  high while in HOLD.

Behaviour:
- Operands: opA/opB selected by ForwardJA/JB. Code 11 is reserved and selects the RF value.
- Condition: taken = Branch & (BranchNe ? opA!=opB : opA==opB).
- Redirect request (combinational): req = (JumpR | Jump | taken) & !stallJ & !stall_load & (state==RUN).
- Target priority is JumpR > Jump > Branch:
  - JumpR: {opA[31:2],2'b00}; low bits are masked.
  - Jump: {IFID_PC4[31:28], JIdx26, 2'b00}.
  - Branch: IFID_PC4 + (sext(Imm16)<<2), modulo 2^32; wrap-around is allowed.
- States: RUN, HOLD (holds pending_target register).
- Reset: PC=RESET_PC, state=RUN, pending_target=0. Outputs after reset: IFID_Write=1, IFID_Flush=0, redirect_pending=0. Reset wins over every other event, including mid-HOLD.
- Per-edge update, in priority order:
  1. ICache_stall=1:
     - PC holds.
     - If req, pending_target<=target and go to HOLD.
     - If already in HOLD, stay.
     - IFID_Write=0, IFID_Flush=0.
  2. HOLD with ICache_stall=0:
     - PC<=pending_target, go to RUN.
     - IFID_Flush=1, IFID_Write=1.
     - Redirect inputs are ignored this cycle because the ID instruction has already resolved.
  3. stallJ|stall_load (RUN):
     - PC holds.
     - IFID_Write=0, IFID_Flush=0.
  4. req:
     - PC<=target.
     - IFID_Flush=1, IFID_Write=1.
  5. Otherwise: PC<=PC+4, IFID_Write=1.
- Redirect latency: a target resolved in cycle N is the fetch address in cycle N+1.
- One wrong-path fetch is squashed by the flush; no delay slot.
- IFID_Flush and IFID_Write are combinational from current state and inputs. PC and state are registered.
- stallJ with ICache_stall: ICache_stall dominates and no req is formed.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds three 32-bit saturating counters, all cleared by rst:
  - br_cnt: branches resolved, i.e. req-eligible cycles with Branch=1.
  - br_taken_cnt: taken branches.
  - stallJ_cyc_cnt: cycles with stallJ=1 & !ICache_stall.
- The counters are exposed on output ports br_cnt, br_taken_cnt and stallJ_cyc_cnt.
- When undefined, the same ports exist and are tied to 0; no counter flops are built.

Decomposition:
- Shared package branch_pkg holds:
  - forwarding-select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - the state enum {RUN, HOLD};
  - the PC increment constant 4.
- One natural sub-module, branch_target_calc: purely combinational operand mux, compare and target generation, driving taken and target.

Test Plan:
- Reset then free run → PC sequence 0,4,8,C; IFID_Write=1; IFID_Flush=0.
- beq with ForwardJA=01, EXMEM_ALUResult=5, RF_ReadData2=5, IFID_PC4=0x100, Imm16=0xFFFF → next PC=0x0FC; IFID_Flush=1 for one cycle.
- jr with stallJ=1 for 2 cycles then 0, opA=0x0000_2003 → PC holds 2 cycles, then PC=0x2000 and flush.
- j with ICache_stall=1 for 3 cycles, IFID_PC4=0x4000_0010, JIdx26=0x40 → redirect_pending=1 during stall; on release PC=0x4000_0100, flush=1, no double redirect.
- Assert rst during HOLD → PC=RESET_PC, redirect_pending=0, pending target discarded.
- BRANCH_STATS_EN: 3 bne (2 taken) plus 4 stallJ cycles → br_cnt=3, br_taken_cnt=2, stallJ_cyc_cnt=4; with the macro undefined, all read 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants and state type for the ID-stage branch/PC unit.
package branch_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational operand forwarding mux, beq/bne compare and redirect target generation.
module branch_target_calc
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      ForwardJA,
  input  logic [1:0]      ForwardJB,
  input  logic [XLEN-1:0] RF_ReadData1,
  input  logic [XLEN-1:0] RF_ReadData2,
  input  logic [XLEN-1:0] EXMEM_ALUResult,
  input  logic [XLEN-1:0] MEMWB_WriteData,
  input  logic [XLEN-1:0] IFID_PC4,
  input  logic            Branch,
  input  logic            BranchNe,
  input  logic            Jump,
  input  logic            JumpR,
  input  logic [15:0]     Imm16,
  input  logic [25:0]     JIdx26,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] br_offset;

  // The reserved select code 2'b11 falls back to the register file value.
  always_comb begin
    op_a = RF_ReadData1;
    case (ForwardJA)
      FWD_EXMEM: op_a = EXMEM_ALUResult;
      FWD_MEMWB: op_a = MEMWB_WriteData;
      default:   op_a = RF_ReadData1;
    endcase
  end

  always_comb begin
    op_b = RF_ReadData2;
    case (ForwardJB)
      FWD_EXMEM: op_b = EXMEM_ALUResult;
      FWD_MEMWB: op_b = MEMWB_WriteData;
      default:   op_b = RF_ReadData2;
    endcase
  end

  assign taken     = Branch & (BranchNe ? (op_a != op_b) : (op_a == op_b));
  assign br_offset = {{(XLEN-18){Imm16[15]}}, Imm16, 2'b00};

  always_comb begin
    target = IFID_PC4 + br_offset;
    if (JumpR)
      target = {op_a[XLEN-1:2], 2'b00};
    else if (Jump)
      target = {IFID_PC4[XLEN-1:XLEN-4], JIdx26, 2'b00};
  end

endmodule

// File: rtl/branch_pc_unit.sv
// ID-stage redirect resolver and PC register; BRANCH_STATS_EN adds branch/stall counters.
// state | meaning
// RUN   | normal fetch; redirects resolve and apply next edge
// HOLD  | redirect resolved under ICache stall; pending_target applied on release
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ICache_stall,
  input  logic            stallJ,
  input  logic            stall_load,
  input  logic [1:0]      ForwardJA,
  input  logic [1:0]      ForwardJB,
  input  logic [XLEN-1:0] RF_ReadData1,
  input  logic [XLEN-1:0] RF_ReadData2,
  input  logic [XLEN-1:0] EXMEM_ALUResult,
  input  logic [XLEN-1:0] MEMWB_WriteData,
  input  logic [XLEN-1:0] IFID_PC4,
  input  logic            Branch,
  input  logic            BranchNe,
  input  logic            Jump,
  input  logic            JumpR,
  input  logic [15:0]     Imm16,
  input  logic [25:0]     JIdx26,
  output logic [XLEN-1:0] PC,
  output logic            IFID_Write,
  output logic            IFID_Flush,
  output logic            redirect_pending,
  output logic [31:0]     br_cnt,
  output logic [31:0]     br_taken_cnt,
  output logic [31:0]     stallJ_cyc_cnt
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pending_q;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            req;

  branch_target_calc #(.XLEN(XLEN)) u_calc (
    .ForwardJA       (ForwardJA),
    .ForwardJB       (ForwardJB),
    .RF_ReadData1    (RF_ReadData1),
    .RF_ReadData2    (RF_ReadData2),
    .EXMEM_ALUResult (EXMEM_ALUResult),
    .MEMWB_WriteData (MEMWB_WriteData),
    .IFID_PC4        (IFID_PC4),
    .Branch          (Branch),
    .BranchNe        (BranchNe),
    .Jump            (Jump),
    .JumpR           (JumpR),
    .Imm16           (Imm16),
    .JIdx26          (JIdx26),
    .taken           (taken),
    .target          (target)
  );

  assign req = (JumpR | Jump | taken) & ~stallJ & ~stall_load & (state_q == RUN);

  always_comb begin
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    if (ICache_stall) begin
      IFID_Write = 1'b0;
    end else if (state_q == HOLD) begin
      IFID_Flush = 1'b1;
    end else if (stallJ | stall_load) begin
      IFID_Write = 1'b0;
    end else if (req) begin
      IFID_Flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      state_q   <= RUN;
      pending_q <= '0;
    end else if (ICache_stall) begin
      if (req) begin
        pending_q <= target;
        state_q   <= HOLD;
      end
    end else if (state_q == HOLD) begin
      pc_q    <= pending_q;
      state_q <= RUN;
    end else if (stallJ | stall_load) begin
      pc_q <= pc_q;
    end else if (req) begin
      pc_q <= target;
    end else begin
      pc_q <= pc_q + XLEN'(PC_INC);
    end
  end

  assign PC               = pc_q;
  assign redirect_pending = (state_q == HOLD);

`ifdef BRANCH_STATS_EN
  logic resolve;

  // A not-taken branch under an ICache stall is counted once, when the stall lifts.
  assign resolve = (state_q == RUN) & ~stallJ & ~stall_load & (~ICache_stall | req);

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt         <= '0;
      br_taken_cnt   <= '0;
      stallJ_cyc_cnt <= '0;
    end else begin
      if (resolve & Branch & (br_cnt != '1))
        br_cnt <= br_cnt + 32'd1;
      if (resolve & taken & (br_taken_cnt != '1))
        br_taken_cnt <= br_taken_cnt + 32'd1;
      if (stallJ & ~ICache_stall & (stallJ_cyc_cnt != '1))
        stallJ_cyc_cnt <= stallJ_cyc_cnt + 32'd1;
    end
  end
`else
  assign br_cnt         = '0;
  assign br_taken_cnt   = '0;
  assign stallJ_cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed-vector bench for branch_pc_unit with hand-computed PC/flush expectations.
module tb_branch_pc_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ICache_stall, stallJ, stall_load;
  logic [1:0]  ForwardJA, ForwardJB;
  logic [31:0] RF_ReadData1, RF_ReadData2, EXMEM_ALUResult, MEMWB_WriteData, IFID_PC4;
  logic        Branch, BranchNe, Jump, JumpR;
  logic [15:0] Imm16;
  logic [25:0] JIdx26;
  logic [31:0] PC;
  logic        IFID_Write, IFID_Flush, redirect_pending;
  logic [31:0] br_cnt, br_taken_cnt, stallJ_cyc_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .ICache_stall(ICache_stall), .stallJ(stallJ),
    .stall_load(stall_load), .ForwardJA(ForwardJA), .ForwardJB(ForwardJB),
    .RF_ReadData1(RF_ReadData1), .RF_ReadData2(RF_ReadData2),
    .EXMEM_ALUResult(EXMEM_ALUResult), .MEMWB_WriteData(MEMWB_WriteData),
    .IFID_PC4(IFID_PC4), .Branch(Branch), .BranchNe(BranchNe), .Jump(Jump),
    .JumpR(JumpR), .Imm16(Imm16), .JIdx26(JIdx26), .PC(PC),
    .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .redirect_pending(redirect_pending), .br_cnt(br_cnt),
    .br_taken_cnt(br_taken_cnt), .stallJ_cyc_cnt(stallJ_cyc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ICache_stall = 0; stallJ = 0; stall_load = 0;
    ForwardJA = FWD_RF; ForwardJB = FWD_RF;
    RF_ReadData1 = 0; RF_ReadData2 = 0; EXMEM_ALUResult = 0; MEMWB_WriteData = 0;
    IFID_PC4 = 0; Branch = 0; BranchNe = 0; Jump = 0; JumpR = 0;
    Imm16 = 0; JIdx26 = 0;
  endtask

  task automatic chk_ctl(input string tag, input logic wr, input logic fl);
    #1;
    chk({tag, "_write"}, {31'd0, IFID_Write}, {31'd0, wr});
    chk({tag, "_flush"}, {31'd0, IFID_Flush}, {31'd0, fl});
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_pend", {31'd0, redirect_pending}, 32'd0);
    chk_ctl("rst", 1'b1, 1'b0);
    tick(); chk("run_pc1", PC, 32'h4);
    tick(); chk("run_pc2", PC, 32'h8);
    tick(); chk("run_pc3", PC, 32'hC);

    // beq taken via EX/MEM forward, negative offset
    Branch = 1; ForwardJA = FWD_EXMEM; EXMEM_ALUResult = 32'd5;
    RF_ReadData1 = 32'd7; RF_ReadData2 = 32'd5; IFID_PC4 = 32'h100; Imm16 = 16'hFFFF;
    chk_ctl("beq", 1'b1, 1'b1);
    tick(); chk("beq_pc", PC, 32'h0FC);
    idle();
    chk_ctl("beq_after", 1'b1, 1'b0);
    tick(); chk("beq_next", PC, 32'h100);

    // bne with equal operands falls through
    Branch = 1; BranchNe = 1; RF_ReadData1 = 32'h55; RF_ReadData2 = 32'h55;
    IFID_PC4 = 32'h104; Imm16 = 16'h0010;
    chk_ctl("bne_nt", 1'b1, 1'b0);
    tick(); chk("bne_nt_pc", PC, 32'h104);

    // branch target wraps past 2^32
    idle();
    Branch = 1; IFID_PC4 = 32'hFFFF_FFFC; Imm16 = 16'h0001;
    tick(); chk("wrap_pc", PC, 32'h0000_0000);

    // jr held by stallJ for two cycles
    idle();
    JumpR = 1; RF_ReadData1 = 32'h0000_2003; stallJ = 1;
    chk_ctl("jr_stall", 1'b0, 1'b0);
    tick(); chk("jr_hold1", PC, 32'h0);
    tick(); chk("jr_hold2", PC, 32'h0);
    stallJ = 0;
    chk_ctl("jr_go", 1'b1, 1'b1);
    tick(); chk("jr_pc", PC, 32'h2000);

    // jr via MEM/WB forward, and reserved select 11 falls back to RF
    idle();
    JumpR = 1; ForwardJA = FWD_MEMWB; MEMWB_WriteData = 32'h7FFF_FFFF;
    tick(); chk("jr_memwb", PC, 32'h7FFF_FFFC);
    ForwardJA = 2'b11; RF_ReadData1 = 32'h3007; EXMEM_ALUResult = 32'h5000;
    MEMWB_WriteData = 32'h6000;
    tick(); chk("jr_rsvd", PC, 32'h3004);

    // JumpR outranks Jump
    Jump = 1; IFID_PC4 = 32'h4000_0010; JIdx26 = 26'h40; RF_ReadData1 = 32'h8888;
    tick(); chk("jr_prio", PC, 32'h8888);

    // load-use stall holds PC
    idle();
    stall_load = 1; Jump = 1; IFID_PC4 = 32'h4000_0010; JIdx26 = 26'h40;
    chk_ctl("ld_stall", 1'b0, 1'b0);
    tick(); chk("ld_hold", PC, 32'h8888);

    // j resolved under a 3-cycle ICache stall
    idle();
    Jump = 1; IFID_PC4 = 32'h4000_0010; JIdx26 = 26'h40; ICache_stall = 1;
    chk_ctl("j_stall", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("j_hold_pc", PC, 32'h8888);
      chk("j_pend", {31'd0, redirect_pending}, 32'd1);
    end
    ICache_stall = 0;
    chk_ctl("j_release", 1'b1, 1'b1);
    tick();
    chk("j_pc", PC, 32'h4000_0100);
    chk("j_pend_clr", {31'd0, redirect_pending}, 32'd0);
    idle();
    chk_ctl("j_no_double", 1'b1, 1'b0);
    tick(); chk("j_next", PC, 32'h4000_0104);

    // reset during HOLD discards the pending target
    Jump = 1; IFID_PC4 = 32'h4000_0010; JIdx26 = 26'h40; ICache_stall = 1;
    tick(); chk("hold_pend", {31'd0, redirect_pending}, 32'd1);
    rst = 1;
    tick();
    chk("hrst_pc", PC, 32'h0);
    chk("hrst_pend", {31'd0, redirect_pending}, 32'd0);
    rst = 0; idle();
    chk_ctl("hrst", 1'b1, 1'b0);
    tick(); chk("hrst_next", PC, 32'h4);

    // counters: 3 bne (2 taken), 4 stallJ cycles, plus one stallJ masked by ICache stall
    Branch = 1; BranchNe = 1; RF_ReadData1 = 32'h1; RF_ReadData2 = 32'h2;
    IFID_PC4 = 32'h8; Imm16 = 16'h0004;
    tick(); chk("bne_t1", PC, 32'h18);
    RF_ReadData2 = 32'h1;
    tick(); chk("bne_nt2", PC, 32'h1C);
    RF_ReadData2 = 32'h3; IFID_PC4 = 32'h20;
    tick(); chk("bne_t3", PC, 32'h30);
    idle();
    stallJ = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("sj_hold", PC, 32'h30);
    ICache_stall = 1;
    chk_ctl("ic_dom", 1'b0, 1'b0);
    tick(); chk("ic_dom_pc", PC, 32'h30);
    idle();
`ifdef BRANCH_STATS_EN
    chk("br_cnt", br_cnt, 32'd3);
    chk("br_taken_cnt", br_taken_cnt, 32'd2);
    chk("stallJ_cyc_cnt", stallJ_cyc_cnt, 32'd4);
`else
    chk("br_cnt", br_cnt, 32'd0);
    chk("br_taken_cnt", br_taken_cnt, 32'd0);
    chk("stallJ_cyc_cnt", stallJ_cyc_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
